// File: rtl/window_3x3_buffer.sv
// window_3x3_buffer
// Takes a greyscale pixel stream (with blanking samples) and produces one 3x3
// neighbourhood per interior pixel. Two previous rows are held in line buffers.
// A long run of blanking samples resynchronises the position to the frame start.
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   in_valid/in_data  - sample strobe and 8-bit pixel
//   in_blank          - sample is blanking (affects only the resync run)
//   win_valid         - window outputs valid this cycle
//   win               - 3x3 window, element (i,j) at [8*(3i+j) +: 8], i/j = 0 oldest
//   win_row/win_col   - position of the window centre
//   win_last          - final window of the frame
module window_3x3_buffer #(
    parameter int unsigned WIDTH      = 400,
    parameter int unsigned HEIGHT     = 300,
    parameter int unsigned VBLANK_MIN = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_blank,
    output logic        win_valid,
    output logic [71:0] win,
    output logic [9:0]  win_row,
    output logic [9:0]  win_col,
    output logic        win_last
);

    localparam int unsigned PW = 8;
    localparam int unsigned CW = 10;
    localparam int unsigned WW = 9 * PW;
    localparam int unsigned AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BW = $clog2(VBLANK_MIN + 1);

    // Position of the next accepted pixel and blank-run length
    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [BW-1:0] blank_q, blank_d;
    // Stage 0: accepted pixel and its position
    logic          acc_q, acc_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [CW-1:0] c_q, c_d, r_q, r_d;
    // Line buffer read data, aligned with stage 0
    logic [PW-1:0] rd0_q, rd1_q;
    // Stage 1: shifting window and emit qualifiers
    logic [WW-1:0] sh_q, sh_d;
    logic          emit_q, emit_d;
    logic          elast_q, elast_d;
    logic [CW-1:0] erow_q, erow_d, ecol_q, ecol_d;
    // Output registers
    logic          win_valid_q, win_valid_d;
    logic          win_last_q, win_last_d;
    logic [WW-1:0] win_q, win_d;
    logic [CW-1:0] win_row_q, win_row_d, win_col_q, win_col_d;

    logic [PW-1:0] lb0_mem [WIDTH];
    logic [PW-1:0] lb1_mem [WIDTH];

    logic accept_c;
    assign accept_c = in_valid && !in_blank;

    // Next-state logic for position, pipeline and outputs
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        blank_d     = blank_q;
        acc_d       = accept_c;
        pix_d       = pix_q;
        c_d         = c_q;
        r_d         = r_q;
        sh_d        = sh_q;
        emit_d      = 1'b0;
        elast_d     = 1'b0;
        erow_d      = erow_q;
        ecol_d      = ecol_q;
        win_valid_d = emit_q;
        win_last_d  = emit_q && elast_q;
        win_d       = win_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;

        // Accept takes precedence over the blank run
        if (accept_c) begin
            blank_d = '0;
            pix_d   = in_data;
            c_d     = col_q;
            r_d     = row_q;
            if (col_q == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == CW'(HEIGHT - 1)) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (in_valid && in_blank) begin
            if (blank_q != BW'(VBLANK_MIN)) begin
                blank_d = blank_q + BW'(1);
            end
            if (blank_d == BW'(VBLANK_MIN)) begin
                col_d = '0;
                row_d = '0;
            end
        end

        // Shift window left; right column is {row r-2, row r-1, row r}
        if (acc_q) begin
            for (int i = 0; i < 3; i++) begin
                sh_d[PW*(3*i)   +: PW] = sh_q[PW*(3*i+1) +: PW];
                sh_d[PW*(3*i+1) +: PW] = sh_q[PW*(3*i+2) +: PW];
            end
            sh_d[PW*2 +: PW] = rd1_q;
            sh_d[PW*5 +: PW] = rd0_q;
            sh_d[PW*8 +: PW] = pix_q;
            emit_d  = (r_q >= CW'(2)) && (c_q >= CW'(2));
            elast_d = (r_q == CW'(HEIGHT - 1)) && (c_q == CW'(WIDTH - 1));
            erow_d  = r_q - CW'(1);
            ecol_d  = c_q - CW'(1);
        end

        if (emit_q) begin
            win_d     = sh_q;
            win_row_d = erow_q;
            win_col_d = ecol_q;
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            blank_q     <= '0;
            acc_q       <= 1'b0;
            pix_q       <= '0;
            c_q         <= '0;
            r_q         <= '0;
            sh_q        <= '0;
            emit_q      <= 1'b0;
            elast_q     <= 1'b0;
            erow_q      <= '0;
            ecol_q      <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_q       <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            blank_q     <= blank_d;
            acc_q       <= acc_d;
            pix_q       <= pix_d;
            c_q         <= c_d;
            r_q         <= r_d;
            sh_q        <= sh_d;
            emit_q      <= emit_d;
            elast_q     <= elast_d;
            erow_q      <= erow_d;
            ecol_q      <= ecol_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_q       <= win_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    // Line buffers: read on accept, write back one cycle later at the same column.
    // Consecutive accepts never share a column, so no read/write collision.
    always_ff @(posedge clock) begin
        if (accept_c) begin
            rd0_q <= lb0_mem[AW'(col_q)];
            rd1_q <= lb1_mem[AW'(col_q)];
        end
        if (acc_q) begin
            lb0_mem[AW'(c_q)] <= pix_q;
            lb1_mem[AW'(c_q)] <= rd0_q;
        end
    end

    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign win       = win_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;

endmodule

// File: tb/tb_window_3x3_buffer.sv
// Directed bench for window_3x3_buffer on a small 8x6 frame with ramp data.
module tb_window_3x3_buffer;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 6;
    localparam int unsigned VB = 24;
    localparam int unsigned HB = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_blank = 1'b0;
    logic        win_valid;
    logic [71:0] win;
    logic [9:0]  win_row;
    logic [9:0]  win_col;
    logic        win_last;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int acc22 = 0;
    int er = 1;
    int ec = 1;
    int win_cnt = 0;
    int last_cnt = 0;

    window_3x3_buffer #(.WIDTH(W), .HEIGHT(H), .VBLANK_MIN(VB)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_blank  (in_blank),
        .win_valid (win_valid),
        .win       (win),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_last  (win_last)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ramp pixel (r,c) = c + 3r; window centred at (r,c)
    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = 8'((c - 1 + j) + 3 * (r - 1 + i));
        return w;
    endfunction

    // Window monitor: windows must arrive in raster order with ramp values
    always @(negedge clock) begin
        if (win_valid) begin
            check("win_row", 72'(win_row), 72'(er));
            check("win_col", 72'(win_col), 72'(ec));
            check("win_data", win, exp_win(er, ec));
            check("win_last", 72'(win_last), 72'((er == H - 2) && (ec == W - 2)));
            if (er == 1 && ec == 1)
                check("latency", 72'(edge_n), 72'(acc22 + 2));
            win_cnt++;
            if (win_last) last_cnt++;
            ec++;
            if (ec > W - 2) begin
                ec = 1;
                er++;
                if (er > H - 2) er = 1;
            end
        end else if (win_last) begin
            check("last_without_valid", 72'(win_last), 72'(0));
        end
    end

    task automatic drive(input logic v, input logic b, input logic [7:0] d);
        in_valid = v;
        in_blank = b;
        in_data  = d;
        @(posedge clock);
        #1;
    endtask

    task automatic send_pix(input int r, input int c);
        drive(1'b1, 1'b0, 8'(c + 3 * r));
        if (r == 2 && c == 2) acc22 = edge_n;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic blanks(input int n);
        repeat (n) drive(1'b1, 1'b1, 8'hFF);
    endtask

    // mode 0: dense, 1: blank after each pixel plus idle gaps, 2: horizontal blanking
    task automatic frame(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pix(r, c);
                if (mode == 1) begin
                    blanks(1);
                    if ((r + c) % 3 == 0) idle(1);
                end
            end
            if (mode == 2) blanks(HB);
        end
    endtask

    task automatic expect_counts(input string tag, input int nwin, input int nlast);
        idle(5);
        check({tag, "_windows"}, 72'(win_cnt), 72'(nwin));
        check({tag, "_lasts"}, 72'(last_cnt), 72'(nlast));
        win_cnt  = 0;
        last_cnt = 0;
    endtask

    task automatic mon_sync();
        er = 1;
        ec = 1;
        win_cnt  = 0;
        last_cnt = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle(3);
        check("rst_win_valid", 72'(win_valid), 72'(0));
        check("rst_win", win, 72'(0));
        check("rst_win_row", 72'(win_row), 72'(0));
        check("rst_win_col", 72'(win_col), 72'(0));
        check("rst_win_last", 72'(win_last), 72'(0));
        reset = 1'b0;
        idle(2);

        frame(0);
        expect_counts("full", (W - 2) * (H - 2), 1);

        frame(1);
        expect_counts("interleaved", (W - 2) * (H - 2), 1);

        frame(2);
        expect_counts("hblank", (W - 2) * (H - 2), 1);

        // Partial frame reaching row 2, then resync
        for (int k = 0; k < 20; k++) send_pix(k / W, k % W);
        blanks(VB);
        idle(3);
        check("partial_windows", 72'(win_cnt), 72'(2));
        mon_sync();
        frame(0);
        expect_counts("resync", (W - 2) * (H - 2), 1);

        // Reset while (3,4) and (3,5) are in flight, with an accept on the reset edge
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++) send_pix(r, c);
        for (int c = 0; c < 6; c++) send_pix(3, c);
        reset = 1'b1;
        send_pix(3, 6);
        check("midrst_valid_0", 72'(win_valid), 72'(0));
        check("midrst_win", win, 72'(0));
        reset = 1'b0;
        idle(1);
        check("midrst_valid_1", 72'(win_valid), 72'(0));
        idle(3);
        check("midrst_windows", 72'(win_cnt), 72'(8));
        mon_sync();
        frame(0);
        expect_counts("after_reset", (W - 2) * (H - 2), 1);

        frame(0);
        blanks(VB);
        frame(0);
        expect_counts("two_frames", 2 * (W - 2) * (H - 2), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
